// File: rtl/time_set_controller.sv
// Time-of-day registers and user time-setting sequencer for the alarm clock.
// Ports: clk, rst_n (async, active-low), tick_1hz, key_mode, key_inc in;
//        six BCD digits, whichtoset (one-hot hour/min/sec), flashenable out.
module time_set_controller #(
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned TIMEOUT_S   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [3:0] showhour1,
  output logic [3:0] showhour0,
  output logic [3:0] showmin1,
  output logic [3:0] showmin0,
  output logic [3:0] showsec1,
  output logic [3:0] showsec0,
  output logic [2:0] whichtoset,
  output logic       flashenable
);

  localparam int unsigned TW = $clog2(TIMEOUT_S + 1);
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

  state_t        r_state, w_next_state;
  logic [7:0]    r_hour, r_min, r_sec;
  logic [7:0]    w_hour, w_min, w_sec;
  logic [2:0]    r_which, w_which;
  logic          r_flash, w_flash;
  logic [HW-1:0] r_hcnt, w_hcnt;
  logic [TW-1:0] r_tcnt, w_tcnt;
  logic          w_timeout, w_inc_ok, w_entry;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return '0;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    w_timeout    = (r_state != RUN) && (r_tcnt == TW'(TIMEOUT_S));
    w_next_state = r_state;
    if (key_mode) begin
      case (r_state)
        RUN:      w_next_state = SET_HOUR;
        SET_HOUR: w_next_state = SET_MIN;
        SET_MIN:  w_next_state = SET_SEC;
        default:  w_next_state = RUN;
      endcase
    end else if (w_timeout) begin
      w_next_state = RUN;
    end
    w_inc_ok = key_inc && !key_mode && !w_timeout && (r_state != RUN);
    w_entry  = (w_next_state != r_state);

    w_hour = r_hour;
    w_min  = r_min;
    w_sec  = r_sec;
    if ((r_state == RUN) && tick_1hz) begin
      w_sec = bcd_inc(r_sec, 8'h59);
      if (r_sec == 8'h59) begin
        w_min = bcd_inc(r_min, 8'h59);
        if (r_min == 8'h59)
          w_hour = bcd_inc(r_hour, 8'h23);
      end
    end else if (w_inc_ok) begin
      case (r_state)
        SET_HOUR: w_hour = bcd_inc(r_hour, 8'h23);
        SET_MIN:  w_min  = bcd_inc(r_min, 8'h59);
        SET_SEC:  w_sec  = bcd_inc(r_sec, 8'h59);
        default:  ;
      endcase
    end

    if ((w_next_state == RUN) || w_entry || key_mode || key_inc)
      w_tcnt = '0;
    else if (tick_1hz)
      w_tcnt = r_tcnt + TW'(1);
    else
      w_tcnt = r_tcnt;

    // hold counter preloads HOLD_CYCLES-1 so the steady phase lasts exactly HOLD_CYCLES
    if (w_next_state == RUN) begin
      w_flash = 1'b1;
      w_hcnt  = '0;
    end else if (w_entry) begin
      w_flash = 1'b0;
      w_hcnt  = '0;
    end else if (w_inc_ok) begin
      w_flash = 1'b1;
      w_hcnt  = HW'(HOLD_CYCLES - 1);
    end else if (r_hcnt != '0) begin
      w_flash = 1'b1;
      w_hcnt  = r_hcnt - HW'(1);
    end else begin
      w_flash = 1'b0;
      w_hcnt  = '0;
    end

    case (w_next_state)
      SET_HOUR: w_which = 3'b100;
      SET_MIN:  w_which = 3'b010;
      SET_SEC:  w_which = 3'b001;
      default:  w_which = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_hour  <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_which <= '0;
      r_flash <= 1'b1;
      r_hcnt  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_hour  <= w_hour;
      r_min   <= w_min;
      r_sec   <= w_sec;
      r_which <= w_which;
      r_flash <= w_flash;
      r_hcnt  <= w_hcnt;
      r_tcnt  <= w_tcnt;
    end
  end

  assign showhour1   = r_hour[7:4];
  assign showhour0   = r_hour[3:0];
  assign showmin1    = r_min[7:4];
  assign showmin0    = r_min[3:0];
  assign showsec1    = r_sec[7:4];
  assign showsec0    = r_sec[3:0];
  assign whichtoset  = r_which;
  assign flashenable = r_flash;

endmodule

// File: tb/tb_time_set_controller.sv
module tb_time_set_controller;

  localparam int HOLD = 4;
  localparam int TOUT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic [3:0] showhour1, showhour0, showmin1, showmin0, showsec1, showsec0;
  logic [2:0] whichtoset;
  logic       flashenable;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_tcnt = 0, m_hold = 0, m_tot = 0;
  bit m_to;

  time_set_controller #(.HOLD_CYCLES(HOLD), .TIMEOUT_S(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .key_mode(key_mode), .key_inc(key_inc),
    .showhour1(showhour1), .showhour0(showhour0), .showmin1(showmin1), .showmin0(showmin0),
    .showsec1(showsec1), .showsec0(showsec0), .whichtoset(whichtoset), .flashenable(flashenable)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [2:0] sel_of(input int mode);
    case (mode)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time kept as plain hour/min/sec integers, mode as 0..3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_tcnt = 0; m_hold = 0;
    end else begin
      m_to = (m_mode != 0) && (m_tcnt == TOUT);
      if (m_mode == 0 && tick_1hz) begin
        m_tot = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h = m_tot / 3600;
        m_m = (m_tot / 60) % 60;
        m_s = m_tot % 60;
      end
      if (key_mode) begin
        m_mode = (m_mode + 1) % 4; m_tcnt = 0; m_hold = 0;
      end else if (m_to) begin
        m_mode = 0; m_tcnt = 0; m_hold = 0;
      end else if (m_mode != 0) begin
        if (key_inc) begin
          if (m_mode == 1) m_h = (m_h + 1) % 24;
          if (m_mode == 2) m_m = (m_m + 1) % 60;
          if (m_mode == 3) m_s = (m_s + 1) % 60;
          m_tcnt = 0;
          m_hold = HOLD;
        end else begin
          if (tick_1hz) m_tcnt++;
          if (m_hold > 0) m_hold--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("digits", 32'({showhour1, showhour0, showmin1, showmin0, showsec1, showsec0}),
            32'(hms(m_h, m_m, m_s)));
      check("whichtoset", 32'(whichtoset), 32'(sel_of(m_mode)));
      check("flashenable", 32'(flashenable), 32'((m_mode == 0) || (m_hold > 0)));
    end
  end

  task automatic step(input bit m, input bit i, input bit t);
    key_mode = m; key_inc = i; tick_1hz = t;
    @(posedge clk); #1;
    key_mode = 1'b0; key_inc = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [23:0] digits();
    return {showhour1, showhour0, showmin1, showmin0, showsec1, showsec0};
  endfunction

  initial begin
    #12;
    check("rst_digits", 32'(digits()), 32'h0);
    check("rst_which", 32'(whichtoset), 32'h0);
    check("rst_flash", 32'(flashenable), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    for (int k = 0; k < 3; k++) begin step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0); end
    check("run_3ticks", 32'(digits()), 32'h000003);
    check("run_which", 32'(whichtoset), 32'h0);

    step(1'b1, 1'b0, 1'b0); incs(23);
    step(1'b1, 1'b0, 1'b0); incs(59);
    step(1'b1, 1'b0, 1'b0); incs(55);
    step(1'b1, 1'b0, 1'b0);
    check("preload", 32'(digits()), 32'h235958);
    step(1'b0, 1'b0, 1'b1);
    check("tick_235959", 32'(digits()), 32'h235959);
    step(1'b0, 1'b0, 1'b1);
    check("day_wrap", 32'(digits()), 32'h000000);

    step(1'b1, 1'b0, 1'b0);
    check("sethour_which", 32'(whichtoset), 32'h4);
    check("sethour_flash", 32'(flashenable), 32'h0);
    incs(25);
    check("hour_wrap", 32'(digits()), 32'h010000);
    check("hold_c1", 32'(flashenable), 32'h1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    check("hold_c4", 32'(flashenable), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("hold_end", 32'(flashenable), 32'h0);
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    check("set_tick_frozen", 32'(digits()), 32'h010000);

    step(1'b1, 1'b0, 1'b0); incs(59);
    check("min_59", 32'(digits()), 32'h015900);
    incs(1);
    check("min_wrap_nocarry", 32'(digits()), 32'h010000);
    step(1'b1, 1'b1, 1'b0);
    check("mode_beats_inc_which", 32'(whichtoset), 32'h1);
    check("mode_beats_inc_time", 32'(digits()), 32'h010000);

    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("sec_inc", 32'(digits()), 32'h010001);
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    check("timeout_restarted", 32'(whichtoset), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("timeout_which", 32'(whichtoset), 32'h0);
    check("timeout_flash", 32'(flashenable), 32'h1);

    step(1'b1, 1'b0, 1'b0); incs(11);
    step(1'b1, 1'b0, 1'b0); incs(34);
    step(1'b1, 1'b0, 1'b0); incs(55);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("pre_rst_time", 32'(digits()), 32'h123456);
    check("pre_rst_which", 32'(whichtoset), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_digits", 32'(digits()), 32'h0);
    check("async_rst_which", 32'(whichtoset), 32'h0);
    check("async_rst_flash", 32'(flashenable), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
